// File: rtl/rca_accum.sv
// rca_accum: frame accumulator behind the 4-bit ripple-carry adder stage.
// Takes COUNT unsigned operands over valid/ready and sums them into ACC_W
// bits, seeded by the frame carry-in. It raises a one-cycle done pulse when
// the frame completes. ovf is sticky and records any carry out of the top bit.
// Optional build macro RCA_ACCUM_SATURATE_EN: when it is defined, an
// overflowing beat clamps sum to all ones instead of letting it wrap.
module rca_accum #(
    parameter int WIDTH = 4,
    parameter int COUNT = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             ci,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    // A COUNT of 1 still needs a 1-bit counter to stay legal.
    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             beat;
    logic [ACC_W:0]   add_full;   // bit ACC_W is the adder carry-out

    assign beat     = in_valid & in_ready;
    assign add_full = {1'b0, sum} + {{(ACC_W + 1 - WIDTH){1'b0}}, in_data};

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next state and outputs. The outputs are decoded from the registered
    // state only, so no input can reach an output combinationally.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ACC;
            end
            S_ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (beat && cnt == CNT_LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: a start in IDLE seeds the frame, and each accepted beat
    // adds one operand. In all other cycles sum, ovf and cnt hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (state == S_IDLE && start) begin
            sum <= {{(ACC_W - 1){1'b0}}, ci};
            ovf <= 1'b0;
            cnt <= '0;
        end else if (state == S_ACC && beat) begin
            cnt <= cnt + 1'b1;
            ovf <= ovf | add_full[ACC_W];
`ifdef RCA_ACCUM_SATURATE_EN
            // An all-ones sum that is already clamped stays pinned, because
            // any nonzero operand carries out again.
            sum <= add_full[ACC_W] ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
            sum <= add_full[ACC_W-1:0];
`endif
        end
    end

endmodule

// File: tb/tb_rca_accum.sv
// Directed bench for rca_accum. It drives a default instance (ACC_W=8) and a
// narrow instance (ACC_W=5) from the same inputs. Inputs change 1ns after
// the rising edge, and outputs are sampled at that same point.
module tb_rca_accum;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       ci;
    logic       in_valid;
    logic [3:0] in_data;

    logic       in_ready, busy, done, ovf;
    logic [7:0] sum;
    logic       in_ready5, busy5, done5, ovf5;
    logic [4:0] sum5;

    int checks = 0;
    int errors = 0;

`ifdef RCA_ACCUM_SATURATE_EN
    localparam logic [4:0] SUM5_3BEAT = 5'd31;
    localparam logic [4:0] SUM5_FINAL = 5'd31;
`else
    localparam logic [4:0] SUM5_3BEAT = 5'd13;   // 45 mod 32
    localparam logic [4:0] SUM5_FINAL = 5'd28;   // 60 mod 32
`endif

    rca_accum #(.WIDTH(4), .COUNT(4), .ACC_W(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ci(ci),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .done(done), .sum(sum), .ovf(ovf)
    );

    rca_accum #(.WIDTH(4), .COUNT(4), .ACC_W(5)) u_dut5 (
        .clk(clk), .reset_n(reset_n), .start(start), .ci(ci),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready5),
        .busy(busy5), .done(done5), .sum(sum5), .ovf(ovf5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic c);
        start = 1'b1;
        ci    = c;
        step();
        start = 1'b0;
        ci    = 1'b0;
    endtask

    task automatic beat(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic frame(input logic c, input logic [3:0] a, b, d0, d1);
        do_start(c);
        beat(a); beat(b); beat(d0); beat(d1);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        ci       = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        chk("rst_sum",      sum,      0);
        chk("rst_ovf",      ovf,      0);
        chk("rst_busy",     busy,     0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done",     done,     0);
        #10 reset_n = 1'b1;
        step();

        // Basic frame: 3+2+1+6 = 12.
        do_start(1'b0);
        chk("acc_in_ready", in_ready, 1);
        chk("acc_busy",     busy,     1);
        chk("seed_ci0",     sum,      0);
        beat(4'd3); beat(4'd2); beat(4'd1);
        chk("no_early_done", done, 0);
        beat(4'd6);
        chk("basic_done",     done,     1);
        chk("basic_in_ready", in_ready, 0);
        chk("basic_busy",     busy,     1);
        chk("basic_sum",      sum,      12);
        chk("basic_ovf",      ovf,      0);
        step();
        chk("basic_done_low", done, 0);
        chk("basic_idle",     busy, 0);
        chk("basic_sum_hold", sum,  12);

        // Carry-in seeds the accumulator: 1+3+2+1+6 = 13.
        do_start(1'b1);
        chk("seed_ci1", sum, 1);
        beat(4'd3); beat(4'd2); beat(4'd1); beat(4'd6);
        chk("ci_sum",  sum,  13);
        chk("ci_done", done, 1);
        step();
        // A new start clears the previous frame's sum.
        frame(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        chk("zero_sum",  sum,  0);
        chk("zero_done", done, 1);
        step();

        // Bubbles, with start pulsed during ACC: 5+4+1+2 = 12.
        do_start(1'b0);
        beat(4'd5);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("bubble_sum_hold", sum,      5);
        chk("bubble_in_ready", in_ready, 1);
        beat(4'd4); beat(4'd1);
        chk("bubble_3_done", done, 0);
        beat(4'd2);
        chk("bubble_done", done, 1);
        chk("bubble_sum",  sum,  12);
        step();
        chk("bubble_done_single", done, 0);
        step();
        chk("bubble_no_restart", busy, 0);
        chk("bubble_sum_final",  sum,  12);

        // Overflow on the 5-bit instance: four operands of 15 = 60.
        do_start(1'b0);
        beat(4'd15); beat(4'd15);
        chk("ovf5_2beat_sum", sum5, 30);
        chk("ovf5_2beat_ovf", ovf5, 0);
        beat(4'd15);
        chk("ovf5_3beat_sum", sum5, SUM5_3BEAT);
        chk("ovf5_3beat_ovf", ovf5, 1);
        beat(4'd15);
        chk("ovf5_sum",  sum5,  SUM5_FINAL);
        chk("ovf5_ovf",  ovf5,  1);
        chk("ovf5_done", done5, 1);
        chk("ovf8_sum",  sum,   60);
        chk("ovf8_ovf",  ovf,   0);
        step();
        chk("ovf5_hold", sum5, SUM5_FINAL);

        // An asynchronous reset mid-frame wipes the partial frame at once.
        do_start(1'b0);
        beat(4'd7); beat(4'd7);
        chk("mid_sum", sum, 14);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_sum",      sum,      0);
        chk("arst_ovf",      ovf,      0);
        chk("arst_busy",     busy,     0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_ovf5",     ovf5,     0);
        #3 reset_n = 1'b1;
        step();
        frame(1'b0, 4'd1, 4'd1, 4'd1, 4'd1);
        chk("post_rst_sum",  sum,  4);
        chk("post_rst_done", done, 1);
        step();

        // In IDLE, in_valid is ignored and sum holds.
        frame(1'b0, 4'd3, 4'd2, 4'd1, 4'd6);
        step();
        in_valid = 1'b1;
        in_data  = 4'd9;
        for (int i = 0; i < 10; i++) begin
            chk("idle_in_ready", in_ready, 0);
            chk("idle_sum",      sum,      12);
            chk("idle_done",     done,     0);
            step();
        end
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
